// File: rtl/mux_arbiter_pkg.sv
// Shared types and constants for the two-requester round-robin mux arbiter.
package mux_arbiter_pkg;

  // Arbiter state: free to arbitrate, or locked to one requester mid-burst
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_t;

  // Source encoding, shared by the mux select, the priority pointer and out_src
  localparam logic SRC_REQ0 = 1'b0;
  localparam logic SRC_REQ1 = 1'b1;

  // Round-robin helper: after serving src, the other requester is favoured
  function automatic logic next_prio(input logic src);
    return (src == SRC_REQ0) ? SRC_REQ1 : SRC_REQ0;
  endfunction

endpackage

// File: rtl/mux_arbiter_mux.sv
// WIDTH-bit 2:1 multiplexor used as the arbiter's shared datapath.
module mux_arbiter_mux #(
  parameter int WIDTH = 5
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] mux_out
);

  // sel=0 passes in0, sel=1 passes in1
  always_comb begin
    mux_out = sel ? in1 : in0;
  end

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin arbiter: two valid/ready requesters share one 2:1 mux into a
// single registered output stage. A beat with last=0 locks the grant to its
// requester until that requester's last beat is accepted.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no burst open; arbitrate between valid requesters by prio
//   ST_LOCK0 | req0 burst open; only req0 eligible, gaps hold the lock
//   ST_LOCK1 | req1 burst open; only req1 eligible, gaps hold the lock
module mux_arbiter
  import mux_arbiter_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req0_last,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  input  logic             req1_last,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready
);

  state_t           state;
  logic             prio;
  logic             sel;
  logic             offer;
  logic             reg_free;
  logic             grant_ok;
  logic             sel_valid;
  logic             sel_last;
  logic             xfer;
  logic [WIDTH-1:0] mux_out;

  mux_arbiter_mux #(
    .WIDTH(WIDTH)
  ) u_mux (
    .sel    (sel),
    .in0    (req0_data),
    .in1    (req1_data),
    .mux_out(mux_out)
  );

  // Pick the requester to serve this cycle and derive the ready handshake
  always_comb begin
    sel   = prio;
    offer = 1'b0;
    unique case (state)
      ST_IDLE: begin
        offer = req0_valid || req1_valid;
        if (req0_valid && !req1_valid) begin
          sel = SRC_REQ0;
        end else if (req1_valid && !req0_valid) begin
          sel = SRC_REQ1;
        end else begin
          sel = prio;
        end
      end
      ST_LOCK0: begin
        sel   = SRC_REQ0;
        offer = 1'b1;
      end
      ST_LOCK1: begin
        sel   = SRC_REQ1;
        offer = 1'b1;
      end
      default: begin
        sel   = prio;
        offer = 1'b0;
      end
    endcase

    reg_free   = !out_valid || out_ready;
    // Gating with rst keeps both readies low during reset, so a beat offered
    // in a reset cycle is never seen as accepted by its requester.
    grant_ok   = !rst && reg_free && offer;
    req0_ready = grant_ok && (sel == SRC_REQ0);
    req1_ready = grant_ok && (sel == SRC_REQ1);
    sel_valid  = (sel == SRC_REQ1) ? req1_valid : req0_valid;
    sel_last   = (sel == SRC_REQ1) ? req1_last  : req0_last;
    xfer       = grant_ok && sel_valid;
  end

  // Arbitration FSM, priority pointer and the registered output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      prio      <= SRC_REQ0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= SRC_REQ0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= mux_out;
        out_src   <= sel;
        unique case (state)
          ST_IDLE: begin
            if (sel_last) begin
              prio <= next_prio(sel);
            end else begin
              state <= (sel == SRC_REQ1) ? ST_LOCK1 : ST_LOCK0;
            end
          end
          ST_LOCK0, ST_LOCK1: begin
            if (sel_last) begin
              state <= ST_IDLE;
              prio  <= next_prio(sel);
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter: each step drives one cycle of stimulus,
// checks the combinational readies against hand-derived values, queues the
// beat expected to be accepted, and compares the output register next cycle.
module tb_mux_arbiter;
  import mux_arbiter_pkg::*;

  localparam int WIDTH = 5;

  logic             clk;
  logic             rst;
  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_last;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_last;
  logic             req1_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_src;
  logic             out_ready;

  int n_checks = 0;
  int n_fails  = 0;

  logic [WIDTH:0] sb_q[$];
  logic           exp_ov;
  logic [WIDTH-1:0] exp_od;
  logic           exp_os;

  mux_arbiter #(
    .WIDTH(WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req0_valid(req0_valid),
    .req0_data (req0_data),
    .req0_last (req0_last),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_data (req1_data),
    .req1_last (req1_last),
    .req1_ready(req1_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WIDTH:0] obs, input logic [WIDTH:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive, check readies mid-cycle, clock, check output register
  task automatic step(input string tag,
                      input bit v0, input bit [WIDTH-1:0] d0, input bit l0,
                      input bit v1, input bit [WIDTH-1:0] d1, input bit l1,
                      input bit ordy, input bit rs, input bit er0, input bit er1);
    bit pushed;
    logic [WIDTH:0] ent;
    rst        = rs;
    req0_valid = v0;
    req0_data  = d0;
    req0_last  = l0;
    req1_valid = v1;
    req1_data  = d1;
    req1_last  = l1;
    out_ready  = ordy;
    #4;
    chk({tag, ".req0_ready"}, {{WIDTH{1'b0}}, req0_ready}, {{WIDTH{1'b0}}, er0});
    chk({tag, ".req1_ready"}, {{WIDTH{1'b0}}, req1_ready}, {{WIDTH{1'b0}}, er1});
    pushed = 1'b0;
    if (er0 && v0) begin
      sb_q.push_back({SRC_REQ0, d0});
      pushed = 1'b1;
    end
    if (er1 && v1) begin
      sb_q.push_back({SRC_REQ1, d1});
      pushed = 1'b1;
    end
    @(posedge clk);
    #1;
    if (rs) begin
      sb_q.delete();
      exp_ov = 1'b0;
      exp_od = '0;
      exp_os = SRC_REQ0;
    end else if (pushed) begin
      if (sb_q.size() == 0) begin
        chk({tag, ".sb_empty"}, 1, 0);
      end else begin
        ent    = sb_q.pop_front();
        exp_ov = 1'b1;
        exp_os = ent[WIDTH];
        exp_od = ent[WIDTH-1:0];
      end
    end else if (exp_ov && ordy) begin
      exp_ov = 1'b0;
    end
    chk({tag, ".out_valid"}, {{WIDTH{1'b0}}, out_valid}, {{WIDTH{1'b0}}, exp_ov});
    chk({tag, ".out_data"},  {1'b0, out_data},           {1'b0, exp_od});
    chk({tag, ".out_src"},   {{WIDTH{1'b0}}, out_src},   {{WIDTH{1'b0}}, exp_os});
  endtask

  initial begin
    rst = 1'b1; req0_valid = 0; req0_data = '0; req0_last = 0;
    req1_valid = 0; req1_data = '0; req1_last = 0; out_ready = 1;
    exp_ov = 0; exp_od = '0; exp_os = 0;
    @(posedge clk);
    #1;

    // reset held, then released idle
    step("rst0", 0, 5'h00, 0, 0, 5'h00, 0, 1, 1, 0, 0);
    step("rst1", 1, 5'h15, 1, 1, 5'h03, 1, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++)
      step("idle", 0, 5'h00, 0, 0, 5'h00, 0, 1, 0, 0, 0);

    // both valid, single beats: alternate starting with req0
    step("rr0", 1, 5'h15, 1, 1, 5'h03, 1, 1, 0, 1, 0);
    step("rr1", 1, 5'h15, 1, 1, 5'h03, 1, 1, 0, 0, 1);
    step("rr2", 1, 5'h15, 1, 1, 5'h03, 1, 1, 0, 1, 0);
    step("rr3", 1, 5'h15, 1, 1, 5'h03, 1, 1, 0, 0, 1);

    // req0 alone once so req1 is favoured next, then req1 burst with a gap
    step("pre",   1, 5'h15, 1, 0, 5'h00, 0, 1, 0, 1, 0);
    step("bst_a", 1, 5'h1F, 1, 1, 5'h0A, 0, 1, 0, 0, 1);
    step("bst_g", 1, 5'h1F, 1, 0, 5'h00, 0, 1, 0, 0, 1);
    step("bst_b", 1, 5'h1F, 1, 1, 5'h0B, 0, 1, 0, 0, 1);
    step("bst_c", 1, 5'h1F, 1, 1, 5'h0C, 1, 1, 0, 0, 1);
    step("bst_r0", 1, 5'h1F, 1, 0, 5'h00, 0, 1, 0, 1, 0);

    // backpressure: output holds 11 while consumer stalls
    step("bp_in", 1, 5'h11, 1, 0, 5'h00, 0, 1, 0, 1, 0);
    for (int i = 0; i < 4; i++)
      step("bp_hold", 1, 5'h12, 1, 0, 5'h00, 0, 0, 0, 0, 0);
    step("bp_rel", 1, 5'h12, 1, 0, 5'h00, 0, 1, 0, 1, 0);

    // lone req1 gets back-to-back grants
    for (int i = 0; i < 4; i++) begin
      bit [WIDTH-1:0] d;
      d = WIDTH'(i + 1);
      step("lone1", 0, 5'h00, 0, 1, d, 1, 1, 0, 0, 1);
    end
    step("drain", 0, 5'h00, 0, 0, 5'h00, 0, 1, 0, 0, 0);

    // reset mid-burst drops the lock: a lone req1 is then served at once
    step("mb_b1", 1, 5'h07, 0, 0, 5'h00, 0, 1, 0, 1, 0);
    step("mb_rst", 1, 5'h08, 0, 1, 5'h0D, 1, 0, 1, 0, 0);
    step("mb_r1", 0, 5'h00, 0, 1, 5'h0E, 1, 1, 0, 0, 1);

    // reset restores prio to req0 even after req1 was favoured
    step("pr_set", 1, 5'h06, 1, 0, 5'h00, 0, 1, 0, 1, 0);
    step("pr_b1",  1, 5'h07, 0, 0, 5'h00, 0, 0, 0, 0, 0);
    step("pr_rst", 0, 5'h00, 0, 0, 5'h00, 0, 0, 1, 0, 0);
    step("pr_both", 1, 5'h09, 1, 1, 5'h0D, 1, 1, 0, 1, 0);
    step("pr_next", 1, 5'h09, 1, 1, 5'h0D, 1, 1, 0, 0, 1);
    step("end", 0, 5'h00, 0, 0, 5'h00, 0, 1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
